// File: rtl/cache_pmem_arbiter.sv
// rtl/cache_pmem_arbiter.sv - shares one physical-memory line port between I-cache and D-cache
//
// Purpose:
//   Grants the memory port to one cache at a time, latches that cache's line
//   transaction, drives it to memory and routes the single-cycle response
//   back to the owner. Simultaneous requests are resolved round-robin.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   i_pmem_read/address               I-cache line read request
//   i_pmem_rdata/resp                 I-cache response (rdata zero unless resp)
//   d_pmem_read/write/address/wdata   D-cache line read / writeback request
//   d_pmem_rdata/resp                 D-cache response (rdata zero unless resp)
//   pmem_read/write/address/wdata     memory request, driven from captured registers
//   pmem_rdata/resp                   memory response

module cache_pmem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int LINE_WIDTH   = 128,
  parameter int RESET_PRIO_D = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;
  // Recording I as the last grant makes D win the first tie, and vice versa.
  localparam logic LAST_GRANT_RST = (RESET_PRIO_D != 0) ? GRANT_I : GRANT_D;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;

  logic i_req;
  logic d_req;
  logic serving;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_GRANT_RST;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    case (state_q)
      IDLE: begin
        // I wins when alone, or on a tie when D had the previous grant.
        if (i_req && (!d_req || last_grant_q == GRANT_D)) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_I;
          addr_d       = i_pmem_address;
          wdata_d      = '0;
          write_d      = 1'b0;
        end else if (d_req) begin
          state_d      = SERVE_D;
          last_grant_d = GRANT_D;
          addr_d       = d_pmem_address;
          wdata_d      = d_pmem_wdata;
          // A writeback takes precedence if the D-cache raises both strobes.
          write_d      = d_pmem_write;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory side comes only from captured registers; outputs fall with the
  // asynchronous reset because state_q does.
  assign serving      = (state_q != IDLE);
  assign pmem_read    = serving & ~write_q;
  assign pmem_write   = serving & write_q;
  assign pmem_address = serving ? addr_q : '0;
  assign pmem_wdata   = serving ? wdata_q : '0;

  assign i_pmem_resp  = (state_q == SERVE_I) & pmem_resp;
  assign d_pmem_resp  = (state_q == SERVE_D) & pmem_resp;
  assign i_pmem_rdata = i_pmem_resp ? pmem_rdata : '0;
  assign d_pmem_rdata = d_pmem_resp ? pmem_rdata : '0;

endmodule

// File: tb/tb_cache_pmem_arbiter.sv
// tb/tb_cache_pmem_arbiter.sv - directed self-checking bench for cache_pmem_arbiter

module tb_cache_pmem_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk;
  logic          rst_n;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int checks = 0;
  int errors = 0;

  localparam logic [LW-1:0] RD_LINE  = 128'hDEAD_BEEF_0000_1111_2222_3333_DEAD_BEEF;
  localparam logic [LW-1:0] WB_LINE  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [LW-1:0] ALT_LINE = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;

  cache_pmem_arbiter #(
    .ADDR_WIDTH  (AW),
    .LINE_WIDTH  (LW),
    .RESET_PRIO_D(1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_pmem_read   (i_pmem_read),
    .i_pmem_address(i_pmem_address),
    .i_pmem_rdata  (i_pmem_rdata),
    .i_pmem_resp   (i_pmem_resp),
    .d_pmem_read   (d_pmem_read),
    .d_pmem_write  (d_pmem_write),
    .d_pmem_address(d_pmem_address),
    .d_pmem_wdata  (d_pmem_wdata),
    .d_pmem_rdata  (d_pmem_rdata),
    .d_pmem_resp   (d_pmem_resp),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_address  (pmem_address),
    .pmem_wdata    (pmem_wdata),
    .pmem_rdata    (pmem_rdata),
    .pmem_resp     (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  logic exp_owner_d [3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    rst_n          = 1'b0;
    i_pmem_read    = 1'b0;
    i_pmem_address = '0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    pmem_rdata     = '0;
    pmem_resp      = 1'b0;

    // Reset state
    cyc();
    settle();
    check("rst_pmem_read",  {127'd0, pmem_read},  '0);
    check("rst_pmem_write", {127'd0, pmem_write}, '0);
    check("rst_address",    {112'd0, pmem_address}, '0);
    check("rst_wdata",      pmem_wdata, '0);
    check("rst_i_resp",     {127'd0, i_pmem_resp}, '0);
    check("rst_d_resp",     {127'd0, d_pmem_resp}, '0);
    check("rst_i_rdata",    i_pmem_rdata, '0);
    check("rst_d_rdata",    d_pmem_rdata, '0);
    cyc();
    rst_n = 1'b1;

    // I read alone, with requester inputs moving mid-transaction
    cyc();
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h1230;
    settle();
    check("i_pre_grant_read", {127'd0, pmem_read}, '0);
    cyc();
    settle();
    check("i_read_strobe",  {127'd0, pmem_read}, 128'd1);
    check("i_write_strobe", {127'd0, pmem_write}, '0);
    check("i_address",      {112'd0, pmem_address}, 128'h1230);
    cyc();
    d_pmem_address = 16'hFFF0;
    i_pmem_address = 16'h9999;
    settle();
    check("i_addr_held", {112'd0, pmem_address}, 128'h1230);
    check("i_no_resp_yet", {127'd0, i_pmem_resp}, '0);
    cyc();
    pmem_resp  = 1'b1;
    pmem_rdata = RD_LINE;
    settle();
    check("i_resp",       {127'd0, i_pmem_resp}, 128'd1);
    check("i_rdata",      i_pmem_rdata, RD_LINE);
    check("i_d_resp_off", {127'd0, d_pmem_resp}, '0);
    check("i_d_rdata_off", d_pmem_rdata, '0);
    cyc();
    pmem_resp   = 1'b0;
    pmem_rdata  = '0;
    i_pmem_read = 1'b0;
    settle();
    check("i_idle_read",  {127'd0, pmem_read}, '0);
    check("i_resp_pulse", {127'd0, i_pmem_resp}, '0);

    // D writeback
    cyc();
    d_pmem_write   = 1'b1;
    d_pmem_address = 16'h04A0;
    d_pmem_wdata   = WB_LINE;
    cyc();
    settle();
    check("wb_write_strobe", {127'd0, pmem_write}, 128'd1);
    check("wb_read_strobe",  {127'd0, pmem_read}, '0);
    check("wb_address",      {112'd0, pmem_address}, 128'h04A0);
    check("wb_wdata",        pmem_wdata, WB_LINE);
    cyc();
    d_pmem_wdata = ALT_LINE;
    settle();
    check("wb_wdata_held", pmem_wdata, WB_LINE);
    cyc();
    pmem_resp = 1'b1;
    settle();
    check("wb_d_resp",  {127'd0, d_pmem_resp}, 128'd1);
    check("wb_i_resp",  {127'd0, i_pmem_resp}, '0);
    cyc();
    pmem_resp    = 1'b0;
    d_pmem_write = 1'b0;
    settle();
    check("wb_resp_pulse", {127'd0, d_pmem_resp}, '0);
    check("wb_idle_write", {127'd0, pmem_write}, '0);

    // Reset in the middle of a D writeback
    cyc();
    d_pmem_write   = 1'b1;
    d_pmem_address = 16'h0777;
    d_pmem_wdata   = WB_LINE;
    cyc();
    settle();
    check("mid_write_strobe", {127'd0, pmem_write}, 128'd1);
    rst_n     = 1'b0;
    pmem_resp = 1'b1;
    #1;
    check("mid_rst_write", {127'd0, pmem_write}, '0);
    check("mid_rst_read",  {127'd0, pmem_read}, '0);
    check("mid_rst_d_resp", {127'd0, d_pmem_resp}, '0);
    check("mid_rst_addr",  {112'd0, pmem_address}, '0);
    cyc();
    pmem_resp    = 1'b0;
    d_pmem_write = 1'b0;
    cyc();
    rst_n = 1'b1;
    settle();
    check("post_rst_idle_write", {127'd0, pmem_write}, '0);
    check("post_rst_idle_read",  {127'd0, pmem_read}, '0);

    // Simultaneous requests right after reset: D first, I after one IDLE cycle
    cyc();
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h1230;
    d_pmem_read    = 1'b1;
    d_pmem_address = 16'h0500;
    cyc();
    settle();
    check("tie1_owner_addr", {112'd0, pmem_address}, 128'h0500);
    check("tie1_read", {127'd0, pmem_read}, 128'd1);
    cyc();
    pmem_resp  = 1'b1;
    pmem_rdata = ALT_LINE;
    settle();
    check("tie1_d_resp",  {127'd0, d_pmem_resp}, 128'd1);
    check("tie1_d_rdata", d_pmem_rdata, ALT_LINE);
    check("tie1_i_resp",  {127'd0, i_pmem_resp}, '0);
    check("tie1_i_rdata", i_pmem_rdata, '0);
    cyc();
    pmem_resp   = 1'b0;
    pmem_rdata  = '0;
    d_pmem_read = 1'b0;
    settle();
    check("tie1_bubble", {127'd0, pmem_read}, '0);
    cyc();
    settle();
    check("tie1_then_i_addr", {112'd0, pmem_address}, 128'h1230);
    cyc();
    pmem_resp = 1'b1;
    settle();
    check("tie1_then_i_resp", {127'd0, i_pmem_resp}, 128'd1);
    cyc();
    pmem_resp   = 1'b0;
    i_pmem_read = 1'b0;

    // Repeated ties alternate owners (last grant was I)
    i_pmem_address = 16'h2000;
    d_pmem_address = 16'h3000;
    for (int r = 0; r < 3; r++) begin
      cyc();
      i_pmem_read = 1'b1;
      d_pmem_read = 1'b1;
      cyc();
      settle();
      check($sformatf("rr%0d_addr", r), {112'd0, pmem_address},
            exp_owner_d[r] ? 128'h3000 : 128'h2000);
      cyc();
      pmem_resp = 1'b1;
      settle();
      check($sformatf("rr%0d_d_resp", r), {127'd0, d_pmem_resp}, {127'd0, exp_owner_d[r]});
      check($sformatf("rr%0d_i_resp", r), {127'd0, i_pmem_resp}, {127'd0, ~exp_owner_d[r]});
      cyc();
      pmem_resp   = 1'b0;
      i_pmem_read = 1'b0;
      d_pmem_read = 1'b0;
    end

    // Stray memory response in IDLE is ignored
    cyc();
    pmem_resp  = 1'b1;
    pmem_rdata = RD_LINE;
    settle();
    check("stray_i_resp",  {127'd0, i_pmem_resp}, '0);
    check("stray_d_resp",  {127'd0, d_pmem_resp}, '0);
    check("stray_i_rdata", i_pmem_rdata, '0);
    check("stray_d_rdata", d_pmem_rdata, '0);
    cyc();
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    settle();
    check("stray_still_idle", {127'd0, pmem_read}, '0);

    // Read and write both high from D: write wins
    d_pmem_read    = 1'b1;
    d_pmem_write   = 1'b1;
    d_pmem_address = 16'h0ABC;
    d_pmem_wdata   = ALT_LINE;
    cyc();
    settle();
    check("ww_write", {127'd0, pmem_write}, 128'd1);
    check("ww_read",  {127'd0, pmem_read}, '0);
    check("ww_wdata", pmem_wdata, ALT_LINE);
    cyc();
    pmem_resp = 1'b1;
    settle();
    check("ww_d_resp", {127'd0, d_pmem_resp}, 128'd1);
    cyc();
    pmem_resp    = 1'b0;
    d_pmem_read  = 1'b0;
    d_pmem_write = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
